// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the seven-segment scan datapath.
package sevseg_pkg;

    localparam int DIGIT_COUNT = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;

    // Select pattern that turns every digit off.
    localparam logic [DIGIT_COUNT-1:0] DIGIT_OFF = 4'b0000;

    // One-hot digit select for a given digit index.
    function automatic logic [DIGIT_COUNT-1:0] digit_onehot(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

    // Nibble of a 16-bit display word belonging to digit idx.
    function automatic nibble_t digit_select(input logic [15:0] word, input digit_idx_t idx);
        nibble_t nib;
        case (idx)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            default: nib = word[15:12];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/seven_seg_scan_prescaler.sv
// Slot prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
// The next-count value is exported so the top can register blanking in step
// with the digit select.
module scan_prescaler #(
    parameter int DIV = 100000
) (
    input  logic                                  clk,
    input  logic                                  reset_i,
    input  logic                                  en_i,
    output logic                                  tick_o,
    output logic [((DIV > 1) ? $clog2(DIV) : 1)-1:0] count_next_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick_o       = en_i && (count_q == TERMINAL);
    assign count_next_o = count_d;

    // Next count: hold when disabled, wrap to zero on the terminal count.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (count_q == TERMINAL) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Four-digit seven-segment scan controller: double-buffered display word,
// rotating one-hot digit select and registered digit nibble.
// Optional feature: define SEVSEG_SCAN_BLANKING_EN to blank the select for
// the first BLANK_CYCLES cycles of every digit slot (anti-ghosting).
module seven_seg_scan_controller
    import sevseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scanEnable,
    input  logic [15:0] displayData,
    input  logic        dataValid,
    output logic [3:0]  switchEnabler,
    output logic [3:0]  digitValue,
    output logic        frameStart
);

`ifdef SEVSEG_SCAN_BLANKING_EN
    localparam bit BLANKING = 1'b1;
`else
    localparam bit BLANKING = 1'b0;
`endif

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    // The prescaler is zero in reset, so the select starts dark when blanking.
    localparam logic [3:0] RESET_SEL = (BLANKING && BLANK_CYCLES > 0) ? DIGIT_OFF : 4'b0001;

    logic             tick;
    logic [CNT_W-1:0] count_next;
    logic             wrap;
    logic             blank_d;

    digit_idx_t  index_q, index_d;
    logic [15:0] pending_q, pending_d;
    logic        pending_full_q, pending_full_d;
    logic [15:0] active_q, active_d;
    logic [3:0]  sel_q, sel_d;
    nibble_t     digit_q, digit_d;
    logic        frame_start_q, frame_start_d;

    scan_prescaler #(
        .DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk         (clk),
        .reset_i     (reset),
        .en_i        (scanEnable),
        .tick_o      (tick),
        .count_next_o(count_next)
    );

    assign wrap = tick && (index_q == 2'd3);

    // Digit index advance and double-buffer update; a strobe coinciding with
    // the wrap bypasses the pending register so the newest word wins.
    always_comb begin
        index_d        = tick ? index_q + 1'b1 : index_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        if (wrap) begin
            if (dataValid) begin
                active_d       = displayData;
                pending_full_d = 1'b0;
            end else if (pending_full_q) begin
                active_d       = pending_q;
                pending_full_d = 1'b0;
            end
        end else if (dataValid) begin
            pending_d      = displayData;
            pending_full_d = 1'b1;
        end
    end

    // Output next-state, derived from the post-edge index and count so the
    // select, nibble and frame pulse all change on the same edge as the index.
    always_comb begin
        blank_d       = BLANKING && (count_next < BLANK_LIM);
        sel_d         = (scanEnable && !blank_d) ? digit_onehot(index_d) : DIGIT_OFF;
        digit_d       = digit_select(active_d, index_d);
        frame_start_d = scanEnable ? wrap : frame_start_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_q        <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= '0;
            sel_q          <= RESET_SEL;
            digit_q        <= '0;
            frame_start_q  <= 1'b0;
        end else begin
            index_q        <= index_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
            sel_q          <= sel_d;
            digit_q        <= digit_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign switchEnabler = sel_q;
    assign digitValue    = digit_q;
    assign frameStart    = frame_start_q;

endmodule
